color_period_sensor: RTL
========================

Name: color_period_sensor

Overview:
- Parametrised successor to the single-shot TCS3200 colour detector.
- Drives the sensor S3/S2 filter select and measures the output period over a configurable number of edges per filter.
- Classifies the reading into red/green/blue/yellow, with per-channel timeout and error reporting.
- Sits between the sensor pins and the game FSM; one start request gives one classification result.

Parameters:
- CNT_W, 24, width of the period counters and period outputs.
- EDGE_LOG2, 3, number of measured edge intervals per channel = 2^EDGE_LOG2.
- SETTLE_CYCLES, 8192, wait cycles after every filter change before edges are accepted (>=1).
- TIMEOUT_CYCLES, 1048576, maximum cycles between consecutive edge flags before the measurement aborts.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- frequencyFromColorSensor  in  1  asynchronous sensor OUT pin
- startDetection  in  1  start request, sampled only in IDLE
- colorSelect  out  2  sensor {S3,S2}: RED=00, GREEN=11, BLUE=10, NONE=01
- busy  out  1  high in every state except IDLE
- detectionComplete  out  1  one-cycle done pulse
- timeout  out  1  error flag, valid with detectionComplete
- color  out  2  00 red, 01 green, 10 blue, 11 yellow
- redPeriod, greenPeriod, bluePeriod  out  CNT_W each  measured cycle counts

Behaviour:
- Reset values: state IDLE, colorSelect=01, busy=0, detectionComplete=0, timeout=0, color=00, all periods=0. Internal counters are cleared.
- Reset mid-measurement aborts immediately. No done pulse is issued.
- Input conditioning: 2-flop synchroniser, then a rising-edge detector, giving a 1-cycle edgeFlag. Latency is fixed; it does not affect period values.
- IDLE:
  - startDetection=1 → SETTLE, colorSelect=RED, busy=1 next cycle.
  - Start while busy is ignored (no queueing).
- SETTLE: counts exactly SETTLE_CYCLES cycles, then → WAIT_EDGE. Edges during SETTLE are ignored.
- WAIT_EDGE: first edgeFlag clears the tick counter → COUNT.
- COUNT:
  - Tick counter increments every cycle and saturates at all-ones.
  - Edge counter increments per edgeFlag.
  - On the 2^EDGE_LOG2-th edge, the stored period = cycle distance between the first edge and this edge (clean period P gives P·2^EDGE_LOG2) → STORE.
- STORE (1 cycle): writes the period of the current channel, then advances RED→GREEN→BLUE with → SETTLE after each. After BLUE → DECIDE.
- DECIDE (1 cycle), with r/g/b as periods (larger = darker):
  - yellow if b>r and b>g;
  - else red if r<g and r<b;
  - else green if g<r and g<b;
  - else blue if b<r and b<g;
  - else red (tie).
  - Then: detectionComplete=1, timeout=0, colorSelect=01, → IDLE.
- Timeout:
  - A gap counter runs in WAIT_EDGE and COUNT and clears on each edgeFlag.
  - Reaching TIMEOUT_CYCLES aborts: current and remaining channel periods = all-ones, color=00, timeout=1, detectionComplete=1, colorSelect=01, → IDLE.
- Outputs color, timeout and periods hold until the next done pulse.
- Simultaneous startDetection and done: start is not accepted in the done cycle (state not yet IDLE).

Optional Feature:
- Macro: COLOR_PERIOD_CLEAR_EN.
- When defined:
  - Adds a fourth CLEAR pass (colorSelect=01) after BLUE, with its own SETTLE/COUNT, and adds output clearPeriod (CNT_W).
  - If clearPeriod > the blue, red and green periods, the result is forced to red with timeout=0 and a new output noObject=1.
  - noObject is 0 otherwise.
- When undefined: no CLEAR pass, no clearPeriod or noObject ports, and the sequence ends after BLUE.

Decomposition:
- Package color_pkg:
  - colour codes (RED_C, GREEN_C, BLUE_C, YELLOW_C);
  - filter select encodings (SEL_RED, SEL_GREEN, SEL_BLUE, SEL_NONE);
  - state enumeration.
- One sub-module, sync_edge_detect: synchroniser plus rising-edge pulse, reset to 0.

Test Plan:
- Square wave P=10 on all channels, EDGE_LOG2=3 → each period=80. Equal periods → color=00 via tie rule; total time ≈ 3·(SETTLE_CYCLES+~90).
- P red=20, green=30, blue=40 → red=160, green=240, blue=320. b is max → color=11 (yellow), timeout=0, one done pulse.
- P red=40, green=12, blue=30 → color=01. P red=40, green=30, blue=12 → color=10.
- Input held low after the RED measurement, TIMEOUT_CYCLES=1000 → done with timeout=1, greenPeriod=bluePeriod=all-ones, color=00.
- Assert reset mid-COUNT → next cycle busy=0, colorSelect=01, all outputs zero, no done pulse. Then a new start completes normally.
- Pulse startDetection repeatedly while busy → exactly one done pulse. Periods unaffected.

Source files
------------

// File: rtl/color_pkg.sv
// Shared codes for the colour period sensor:
// colour results, filter selects, FSM states.
package color_pkg;

  localparam logic [1:0] RED_C    = 2'b00;
  localparam logic [1:0] GREEN_C  = 2'b01;
  localparam logic [1:0] BLUE_C   = 2'b10;
  localparam logic [1:0] YELLOW_C = 2'b11;

  localparam logic [1:0] SEL_RED   = 2'b00;
  localparam logic [1:0] SEL_GREEN = 2'b11;
  localparam logic [1:0] SEL_BLUE  = 2'b10;
  localparam logic [1:0] SEL_NONE  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_WAIT_EDGE,
    ST_COUNT,
    ST_STORE,
    ST_DECIDE
  } state_t;

  typedef enum logic [1:0] {
    CH_RED,
    CH_GREEN,
    CH_BLUE,
    CH_CLEAR
  } chan_t;

  function automatic logic [1:0] sel_of(input chan_t c);
    logic [1:0] s;
    s = SEL_NONE;
    unique case (c)
      CH_RED:   s = SEL_RED;
      CH_GREEN: s = SEL_GREEN;
      CH_BLUE:  s = SEL_BLUE;
      CH_CLEAR: s = SEL_NONE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/color_period_sensor_sync_edge_detect.sv
// Two-flop synchroniser for the sensor pin plus a
// single-cycle rising-edge pulse.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic [2:0] sh;

  always_ff @(posedge clk) begin
    if (reset) sh <= '0;
    else       sh <= {sh[1:0], din};
  end

  assign pulse = sh[1] & ~sh[2];

endmodule

// File: rtl/color_period_sensor.sv
// TCS3200 period-measuring colour classifier.
// Define COLOR_PERIOD_CLEAR_EN to add the unfiltered CLEAR pass.
module color_period_sensor
  import color_pkg::*;
#(
  parameter int CNT_W          = 24,
  parameter int EDGE_LOG2      = 3,
  parameter int SETTLE_CYCLES  = 8192,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frequencyFromColorSensor,
  input  logic             startDetection,
  output logic [1:0]       colorSelect,
  output logic             busy,
  output logic             detectionComplete,
  output logic             timeout,
  output logic [1:0]       color,
  output logic [CNT_W-1:0] redPeriod,
  output logic [CNT_W-1:0] greenPeriod,
`ifdef COLOR_PERIOD_CLEAR_EN
  output logic [CNT_W-1:0] bluePeriod,
  output logic [CNT_W-1:0] clearPeriod,
  output logic             noObject
`else
  output logic [CNT_W-1:0] bluePeriod
`endif
);

`ifdef COLOR_PERIOD_CLEAR_EN
  localparam chan_t LAST_CH = CH_CLEAR;
`else
  localparam chan_t LAST_CH = CH_BLUE;
`endif

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] ONES = '1;
  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(SETTLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(TIMEOUT_CYCLES - 1);
  localparam logic [EDGE_LOG2-1:0] EDGE_LAST = '1;

  state_t               state;
  chan_t                ch;
  chan_t                ch_next;
  logic [SW-1:0]        settle_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [EDGE_LOG2-1:0] edge_cnt;
  logic [CNT_W-1:0]     tick;
  logic [CNT_W-1:0]     tick_inc;
  logic [CNT_W-1:0]     period;
  logic [CNT_W-1:0]     r_m;
  logic [CNT_W-1:0]     g_m;
  logic [CNT_W-1:0]     b_m;
  logic                 edge_flag;
`ifdef COLOR_PERIOD_CLEAR_EN
  logic [CNT_W-1:0]     c_m;
`endif

  sync_edge_detect u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (frequencyFromColorSensor),
    .pulse (edge_flag)
  );

  assign ch_next  = chan_t'(ch + 2'd1);
  assign tick_inc = (tick == ONES) ? ONES : tick + 1'b1;

  // Larger period means a darker channel.
  function automatic logic [1:0] classify(
    input logic [CNT_W-1:0] r,
    input logic [CNT_W-1:0] g,
    input logic [CNT_W-1:0] b
  );
    if (b > r && b > g)      return YELLOW_C;
    else if (r < g && r < b) return RED_C;
    else if (g < r && g < b) return GREEN_C;
    else if (b < r && b < g) return BLUE_C;
    else                     return RED_C;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= ST_IDLE;
      ch                <= CH_RED;
      settle_cnt        <= '0;
      gap_cnt           <= '0;
      edge_cnt          <= '0;
      tick              <= '0;
      period            <= '0;
      r_m               <= '0;
      g_m               <= '0;
      b_m               <= '0;
      colorSelect       <= SEL_NONE;
      busy              <= 1'b0;
      detectionComplete <= 1'b0;
      timeout           <= 1'b0;
      color             <= RED_C;
      redPeriod         <= '0;
      greenPeriod       <= '0;
      bluePeriod        <= '0;
`ifdef COLOR_PERIOD_CLEAR_EN
      c_m               <= '0;
      clearPeriod       <= '0;
      noObject          <= 1'b0;
`endif
    end else begin
      detectionComplete <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // A done pulse still in flight blocks a new start.
          if (startDetection && !detectionComplete) begin
            state       <= ST_SETTLE;
            ch          <= CH_RED;
            colorSelect <= SEL_RED;
            busy        <= 1'b1;
            settle_cnt  <= '0;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state   <= ST_WAIT_EDGE;
            gap_cnt <= '0;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_WAIT_EDGE, ST_COUNT: begin
          if (edge_flag) begin
            gap_cnt <= '0;
            if (state == ST_WAIT_EDGE) begin
              tick     <= '0;
              edge_cnt <= '0;
              state    <= ST_COUNT;
            end else begin
              tick     <= tick_inc;
              edge_cnt <= edge_cnt + 1'b1;
              if (edge_cnt == EDGE_LAST) begin
                period <= tick_inc;
                state  <= ST_STORE;
              end
            end
          end else if (gap_cnt == GAP_LAST) begin
            state             <= ST_IDLE;
            busy              <= 1'b0;
            detectionComplete <= 1'b1;
            timeout           <= 1'b1;
            color             <= RED_C;
            colorSelect       <= SEL_NONE;
            redPeriod   <= (ch > CH_RED)   ? r_m : ONES;
            greenPeriod <= (ch > CH_GREEN) ? g_m : ONES;
            bluePeriod  <= (ch > CH_BLUE)  ? b_m : ONES;
`ifdef COLOR_PERIOD_CLEAR_EN
            clearPeriod <= ONES;
            noObject    <= 1'b0;
`endif
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (state == ST_COUNT) tick <= tick_inc;
          end
        end
        ST_STORE: begin
          unique case (ch)
            CH_RED:   r_m <= period;
            CH_GREEN: g_m <= period;
            CH_BLUE:  b_m <= period;
            CH_CLEAR: begin
`ifdef COLOR_PERIOD_CLEAR_EN
              c_m <= period;
`endif
            end
          endcase
          if (ch == LAST_CH) begin
            state <= ST_DECIDE;
          end else begin
            ch          <= ch_next;
            colorSelect <= sel_of(ch_next);
            settle_cnt  <= '0;
            state       <= ST_SETTLE;
          end
        end
        ST_DECIDE: begin
          state             <= ST_IDLE;
          busy              <= 1'b0;
          detectionComplete <= 1'b1;
          timeout           <= 1'b0;
          colorSelect       <= SEL_NONE;
          redPeriod         <= r_m;
          greenPeriod       <= g_m;
          bluePeriod        <= b_m;
`ifdef COLOR_PERIOD_CLEAR_EN
          clearPeriod <= c_m;
          if (c_m > r_m && c_m > g_m && c_m > b_m) begin
            color    <= RED_C;
            noObject <= 1'b1;
          end else begin
            color    <= classify(r_m, g_m, b_m);
            noObject <= 1'b0;
          end
`else
          color <= classify(r_m, g_m, b_m);
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
